rom_pixel_prefetch: RTL and testbench

//  Fetch stage between the image drom (read port b) and controlador_vga.

---
 rtl/rida_video_pkg.sv | 21 ++
 rtl/pixel_word_fifo.sv | 65 ++++++
 rtl/rom_pixel_prefetch.sv | 180 ++++++++++++++++++
 tb/tb_rom_pixel_prefetch.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rida_video_pkg.sv
// rida_video_pkg: shared widths, FSM state type and ROM word type for the
// drom -> VGA pixel fetch path.
package rida_video_pkg;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } prefetch_state_t;

    typedef logic [WORD_W-1:0] rom_word_t;

    // Next sequential word address, wrapping to 0 after the last image word.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input int unsigned num_words);
        return (addr == 32'(num_words - 1)) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/pixel_word_fifo.sv
// pixel_word_fifo: synchronous DEPTH x 32 word FIFO with flush, occupancy
// count and full/empty flags. Read data is show-ahead (head word visible
// while not empty). Push together with pop is accepted when full.
module pixel_word_fifo
    import rida_video_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clock_25,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  rom_word_t                    wr_data,
    output rom_word_t                    rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rom_word_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage write; left without reset so it maps onto plain RAM.
    always_ff @(posedge clock_25) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; flush discards all stored words.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/rom_pixel_prefetch.sv
// rom_pixel_prefetch: streams image words from drom port b into a word FIFO,
// unpacks them low byte first and hands one pixel per pix_req to the VGA
// controller. Optional macro UNDERFLOW_CNT_EN adds a saturating
// underflow_cnt[15:0] output.
module rom_pixel_prefetch
    import rida_video_pkg::*;
#(
    parameter int IMG_W        = 256,
    parameter int IMG_H        = 256,
    parameter int PIX_PER_WORD = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int ROM_LAT      = 2
) (
    input  logic              clock_25,
    input  logic              reset,
    input  logic              start,
    input  logic              frame_sync,
    output logic [31:0]       rom_address,
    input  rom_word_t         rom_data,
    input  logic              pix_req,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_data,
    output logic              underflow
`ifdef UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);
    localparam int NUM_WORDS = IMG_W * IMG_H / PIX_PER_WORD;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    prefetch_state_t     state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [ROM_LAT-1:0]  inflight_q, inflight_d;
    rom_word_t           word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                underflow_q, underflow_d;

    logic                clear;
    logic                issue;
    logic                take;
    logic                last_byte;
    logic                ufl_evt;
    int                  inflight_cnt;

    logic                fifo_push;
    logic                fifo_pop;
    rom_word_t           fifo_rd_data;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    pixel_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_25 (clock_25),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (clear),
        .wr_data  (rom_data),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Number of ROM reads issued whose data has not yet returned.
    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight_cnt += int'(inflight_q[i]);
        end
    end

    // Control events: a restart (start, or frame_sync once running) flushes
    // everything; reads are only issued when the FIFO can absorb every
    // outstanding return, so a push never meets a full FIFO without a pop.
    always_comb begin
        clear     = start || (frame_sync && (state_q != IDLE));
        issue     = (state_q == FETCH) && !clear && !fifo_full &&
                    ((int'(fifo_count) + inflight_cnt) < FIFO_DEPTH);
        fifo_push = inflight_q[ROM_LAT-1] && !clear;
        take      = pix_req && valid_q && !clear;
        last_byte = (idx_q == IDX_W'(PIX_PER_WORD - 1));
        fifo_pop  = !clear && !fifo_empty && (!valid_q || (take && last_byte));
        ufl_evt   = pix_req && !valid_q;
    end

    // Next state for the FSM, address counter, in-flight tracker and unpacker.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        inflight_d  = clear ? '0 : ((inflight_q << 1) | ROM_LAT'(issue));
        word_d      = word_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        underflow_d = start ? 1'b0 : (underflow_q || ufl_evt);

        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (start || frame_sync) state_d = FLUSH;
            FLUSH:   state_d = (start || frame_sync) ? FLUSH : FETCH;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            addr_d = '0;
        end else if (issue) begin
            addr_d = wrap_inc(addr_q, NUM_WORDS);
        end

        if (clear) begin
            word_d  = '0;
            idx_d   = '0;
            valid_d = 1'b0;
        end else if (take && !last_byte) begin
            word_d = word_q >> PIX_W;
            idx_d  = idx_q + IDX_W'(1);
        end else if (!valid_q || take) begin
            // Last byte consumed (or nothing held): the next word loads in
            // the same cycle so there is no bubble while the FIFO has data.
            if (!fifo_empty) begin
                word_d  = fifo_rd_data;
                idx_d   = '0;
                valid_d = 1'b1;
            end else begin
                word_d  = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    // State register for the FSM and all datapath registers.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            inflight_q  <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign rom_address = addr_q;
    assign pix_valid   = valid_q;
    assign pix_data    = word_q[PIX_W-1:0];
    assign underflow   = underflow_q;

`ifdef UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q;

    // Saturating count of cycles where the consumer asked with nothing ready.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            ucnt_q <= '0;
        end else if (start) begin
            ucnt_q <= '0;
        end else if (ufl_evt && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_rom_pixel_prefetch.sv
// tb_rom_pixel_prefetch: scoreboard bench for rom_pixel_prefetch on an 8x8
// image (16 ROM words). Expected pixels are queued when a stream is started
// and checked as the consumer takes them. Honours UNDERFLOW_CNT_EN.
module tb_rom_pixel_prefetch;
    import rida_video_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int PPW   = 4;
    localparam int DEPTH = 8;
    localparam int LAT   = 2;
    localparam int NW    = IMG_W * IMG_H / PPW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        frame_sync = 1'b0;
    logic        pix_req = 1'b0;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        underflow;
`ifdef UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    logic [31:0] rom [NW];
    logic [31:0] rom_pipe;

    int          vectors = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  sb_exp;
    logic        sb_en = 1'b0;
    logic [7:0]  seen [128];
    int          take_idx = 0;

    rom_pixel_prefetch #(
        .IMG_W        (IMG_W),
        .IMG_H        (IMG_H),
        .PIX_PER_WORD (PPW),
        .FIFO_DEPTH   (DEPTH),
        .ROM_LAT      (LAT)
    ) dut (
        .clock_25    (clk),
        .reset       (rst_n),
        .start       (start),
        .frame_sync  (frame_sync),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .pix_req     (pix_req),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .underflow   (underflow)
`ifdef UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #20 clk = ~clk;

    // Two-cycle synchronous ROM model (port b).
    always @(posedge clk) begin
        rom_pipe <= rom[rom_address[3:0]];
        rom_data <= rom_pipe;
    end

    // Scoreboard: every pixel the consumer takes is popped and compared.
    always @(negedge clk) begin
        if (sb_en && rst_n && pix_req && pix_valid && !start && !frame_sync) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underrun: pixel %02h taken, expected none", pix_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (pix_data !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_pixel #%0d: got %02h expected %02h", take_idx, pix_data, sb_exp);
                end else begin
                    $display("pixel #%0d: %02h", take_idx, pix_data);
                end
            end
            if (take_idx < 128) seen[take_idx] = pix_data;
            take_idx++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input int mode);
        for (int k = 0; k < NW; k++) begin
            if (mode == 0) rom[k] = {4{8'(k)}};
            else           rom[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        end
    endtask

    task automatic push_words(input int first, input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = rom[(first + i) % NW];
            for (int b = 0; b < PPW; b++) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        vectors += 4;
        if (rom_address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rom_address); end
        if (pix_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
        if (pix_data !== 8'h00)    begin errors++; $display("FAIL reset_data: got %02h expected 00", pix_data); end
        if (underflow !== 1'b0)    begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        $display("reset: addr=%0d valid=%b data=%02h underflow=%b", rom_address, pix_valid, pix_data, underflow);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        int gaps = 0;
        fill_rom(0);
        exp_q.delete();
        push_words(0, 24);
        take_idx = 0;
        sb_en = 1'b1;
        tick(); start = 1'b1; pix_req = 1'b1;
        tick(); start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (rom_address !== 32'd0) begin errors++; $display("FAIL stream_addr_c1: got %0d expected 0", rom_address); end
            end
            if (c == 2) begin
                vectors++;
                if (rom_address !== 32'd1) begin errors++; $display("FAIL stream_addr_c2: got %0d expected 1", rom_address); end
            end
            if (c == LAT + 2) begin
                vectors++;
                if (pix_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid: got %b expected 0", pix_valid); end
            end
            if (c == LAT + 3) begin
                vectors++;
                if (pix_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid: got %b expected 1", pix_valid); end
            end
            if (c > LAT + 3 && pix_valid !== 1'b1) gaps++;
            tick();
        end
        pix_req = 1'b0;
        vectors += 2;
        if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left: got %0d pixels unconsumed expected 0", exp_q.size()); end
        $display("stream: 96 pixels, gaps=%0d", gaps);
    endtask

    task automatic test_byte_order();
        logic [7:0] order [4];
        order[0] = 8'hAA; order[1] = 8'hBB; order[2] = 8'hCC; order[3] = 8'hDD;
        rom[0] = 32'hDDCCBBAA;
        exp_q.delete();
        push_words(0, 4);
        take_idx = 0;
        tick(); start = 1'b1; pix_req = 1'b0;
        tick(); start = 1'b0; pix_req = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c >= LAT + 4 && c <= LAT + 7) begin
                vectors++;
                if (pix_valid !== 1'b1 || pix_data !== order[c - LAT - 4]) begin
                    errors++;
                    $display("FAIL byte_order_%0d: got valid=%b data=%02h expected %02h",
                             c - LAT - 4, pix_valid, pix_data, order[c - LAT - 4]);
                end
            end
            tick();
        end
        pix_req = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL byte_order_left: got %0d expected 0", exp_q.size()); end
        $display("byte_order: word0=DDCCBBAA checked");
    endtask

    task automatic test_wrap();
        int bad_steps = 0;
        int wraps = 0;
        logic [31:0] prev = '0;
        fill_rom(1);
        exp_q.delete();
        push_words(0, 20);
        take_idx = 0;
        tick(); start = 1'b1; pix_req = 1'b0;
        tick(); start = 1'b0; pix_req = 1'b1;
        for (int c = 1; c <= 85; c++) begin
            @(negedge clk);
            if (c >= 3 && rom_address !== prev) begin
                if (rom_address !== (prev + 32'd1) % NW) bad_steps++;
                if (prev == 32'(NW - 1) && rom_address == 32'd0) wraps++;
            end
            prev = rom_address;
            tick();
        end
        pix_req = 1'b0;
        vectors += 4;
        if (bad_steps != 0) begin errors++; $display("FAIL wrap_steps: got %0d bad steps expected 0", bad_steps); end
        if (wraps < 1)      begin errors++; $display("FAIL wrap_seen: got %0d wraps expected >=1", wraps); end
        if (seen[64] !== rom[0][7:0] || seen[64] !== seen[0]) begin
            errors++;
            $display("FAIL wrap_pix64: got %02h (pix0 %02h) expected %02h", seen[64], seen[0], rom[0][7:0]);
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_left: got %0d expected 0", exp_q.size()); end
        $display("wrap: wraps=%0d pix64=%02h", wraps, seen[64]);
    endtask

    task automatic test_back_pressure();
        int gaps = 0;
        exp_q.delete();
        push_words(0, 24);
        take_idx = 0;
        tick(); start = 1'b1; pix_req = 1'b0;
        tick(); start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 40) begin
                vectors += 2;
                if (rom_address !== 32'(DEPTH + 1)) begin
                    errors++; $display("FAIL stall_reads: got addr %0d expected %0d", rom_address, DEPTH + 1);
                end
                if (underflow !== 1'b0) begin errors++; $display("FAIL stall_underflow: got %b expected 0", underflow); end
            end
            tick();
        end
        pix_req = 1'b1;
        for (int c = 41; c <= 136; c++) begin
            @(negedge clk);
            if (pix_valid !== 1'b1) gaps++;
            tick();
        end
        pix_req = 1'b0;
        vectors += 2;
        if (gaps != 0) begin errors++; $display("FAIL resume_gaps: got %0d expected 0", gaps); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL resume_left: got %0d expected 0", exp_q.size()); end
        $display("back_pressure: stalled addr ok, resume gaps=%0d", gaps);
    endtask

    task automatic test_frame_sync();
        exp_q.delete();
        push_words(0, 8);
        take_idx = 0;
        tick(); start = 1'b1; pix_req = 1'b0;
        tick(); start = 1'b0; pix_req = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            if (c == 11) begin
                frame_sync = 1'b1;
                exp_q.delete();
                push_words(0, 8);
            end else begin
                frame_sync = 1'b0;
            end
            @(negedge clk);
            if (c == 12) begin
                vectors++;
                if (pix_valid !== 1'b0) begin errors++; $display("FAIL fsync_flush_valid: got %b expected 0", pix_valid); end
            end
            if (c == 17) begin
                vectors++;
                if (pix_valid !== 1'b1 || pix_data !== rom[0][7:0]) begin
                    errors++;
                    $display("FAIL fsync_restart: got valid=%b data=%02h expected 1/%02h", pix_valid, pix_data, rom[0][7:0]);
                end
            end
            tick();
        end
        frame_sync = 1'b0;
        pix_req = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fsync_left: got %0d expected 0", exp_q.size()); end
        $display("frame_sync: restart at word 0 checked");
    endtask

    task automatic test_underflow();
        sb_en = 1'b0;
        tick(); start = 1'b1; pix_req = 1'b0;
        tick(); start = 1'b0; pix_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL ufl_cleared: got %b expected 0", underflow); end
        tick();
        tick();
        tick(); pix_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL ufl_set: got %b expected 1", underflow); end
`ifdef UNDERFLOW_CNT_EN
        vectors++;
        if (underflow_cnt !== 16'd3) begin errors++; $display("FAIL ufl_cnt: got %0d expected 3", underflow_cnt); end
`endif
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        vectors++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL ufl_start_clear: got %b expected 0", underflow); end
`ifdef UNDERFLOW_CNT_EN
        vectors++;
        if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL ufl_cnt_clear: got %0d expected 0", underflow_cnt); end
`endif
        $display("underflow: set after 3 early requests, cleared by start");
        tick();
    endtask

    task automatic test_reset_midstream();
        pix_req = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        @(negedge clk);
        rst_n = 1'b0;
        pix_req = 1'b0;
        #1;
        vectors += 4;
        if (rom_address !== 32'd0) begin errors++; $display("FAIL rst_mid_addr: got %0d expected 0", rom_address); end
        if (pix_valid !== 1'b0)    begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", pix_valid); end
        if (pix_data !== 8'h00)    begin errors++; $display("FAIL rst_mid_data: got %02h expected 00", pix_data); end
        if (underflow !== 1'b0)    begin errors++; $display("FAIL rst_mid_underflow: got %b expected 0", underflow); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        @(negedge clk);
        vectors += 2;
        if (rom_address !== 32'd0) begin errors++; $display("FAIL rst_idle_addr: got %0d expected 0", rom_address); end
        if (pix_valid !== 1'b0)    begin errors++; $display("FAIL rst_idle_valid: got %b expected 0", pix_valid); end
        $display("reset_midstream: async clear and idle hold checked");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_byte_order();
        test_wrap();
        test_back_pressure();
        test_frame_sync();
        test_underflow();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
